// File: rtl/prefetcher_pkg.sv
// Shared opcode and error-code definitions for the prefetch data queue.
package prefetcher_pkg;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    INVALIDATE = 3'd1,
    READ       = 3'd2,
    WRITE_REQ  = 3'd3,
    WRITE_RESP = 3'd4
  } opcode_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNMATCHED = 2'd1;
  localparam logic [1:0] ERR_FULL      = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

endpackage

// File: rtl/prefetcher_addr_match.sv
// Priority CAM lookup: returns the qualified matching entry nearest the queue head.
module prefetcher_addr_match #(
  parameter int LOG_QUEUE_SIZE = 3,
  parameter int ADDR_BITS      = 64
) (
  input  logic [ADDR_BITS-1:0]      entryAddr [1<<LOG_QUEUE_SIZE],
  input  logic [(1<<LOG_QUEUE_SIZE)-1:0] validMask,
  input  logic [(1<<LOG_QUEUE_SIZE)-1:0] qualMask,
  input  logic [LOG_QUEUE_SIZE-1:0] headPtr,
  input  logic [ADDR_BITS-1:0]      key,
  output logic                      addrHit,
  output logic [LOG_QUEUE_SIZE-1:0] addrIdx
);

  localparam int QS = 1 << LOG_QUEUE_SIZE;

  logic [LOG_QUEUE_SIZE-1:0] idx;

  // Scan from the far end toward head so the last hit written is the nearest one.
  always_comb begin
    addrHit = 1'b0;
    addrIdx = '0;
    idx     = '0;
    for (int k = QS - 1; k >= 0; k--) begin
      idx = headPtr + LOG_QUEUE_SIZE'(k);
      if (validMask[idx] && qualMask[idx] && (entryAddr[idx] == key)) begin
        addrHit = 1'b1;
        addrIdx = idx;
      end
    end
  end

endmodule

// File: rtl/prefetcher_data.sv
// Prefetch data queue: circular FIFO of block entries with CAM lookup, fill and read-pop.
// Optional build macro PREFETCHER_DATA_ASSERT_EN compiles in runtime assertions.
module prefetcher_data
  import prefetcher_pkg::*;
#(
  parameter int LOG_QUEUE_SIZE       = 3,
  parameter int LOG_BLOCK_DATA_BYTES = 3,
  parameter int ADDR_BITS            = 64,
  localparam int BLOCK_DATA_SIZE_BITS = 8 * (1 << LOG_BLOCK_DATA_BYTES)
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [0:ADDR_BITS-1]          reqAddr,
  input  logic [0:BLOCK_DATA_SIZE_BITS-1] reqData,
  input  logic [0:2]                    reqOpcode,
  input  logic [0:LOG_QUEUE_SIZE-1]     crs_almostFullSpacer,
  output logic                          respValid,
  output logic [0:BLOCK_DATA_SIZE_BITS-1] respData,
  output logic [0:LOG_QUEUE_SIZE]       outstandingReqCnt,
  output logic                          almostFull,
  output logic [0:1]                    errorCode
);

  localparam int QS = 1 << LOG_QUEUE_SIZE;
  localparam int DW = BLOCK_DATA_SIZE_BITS;
  localparam logic [LOG_QUEUE_SIZE:0] QS_CNT = (LOG_QUEUE_SIZE+1)'(QS);

  logic [QS-1:0]             valid_q, valid_d;
  logic [QS-1:0]             dvalid_q, dvalid_d;
  logic [QS-1:0]             outst_q, outst_d;
  logic [ADDR_BITS-1:0]      addr_q [QS];
  logic [ADDR_BITS-1:0]      addr_d [QS];
  logic [DW-1:0]             data_q [QS];
  logic [DW-1:0]             data_d [QS];
  logic [LOG_QUEUE_SIZE-1:0] head_q, head_d;
  logic [LOG_QUEUE_SIZE-1:0] tail_q, tail_d;
  logic [LOG_QUEUE_SIZE:0]   valid_cnt_q, valid_cnt_d;
  logic [LOG_QUEUE_SIZE:0]   outst_cnt_q, outst_cnt_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [DW-1:0]             resp_data_q, resp_data_d;
  logic [1:0]                err_q, err_d;

  logic [ADDR_BITS-1:0]      key;
  logic [QS-1:0]             qual;
  logic                      hit;
  logic [LOG_QUEUE_SIZE-1:0] hit_idx;
  logic [LOG_QUEUE_SIZE-1:0] head_p1;
  logic                      is_full;

  assign key     = reqAddr;
  assign head_p1 = head_q + 1'b1;
  assign is_full = (valid_cnt_q == QS_CNT);
  // Fill responses may only land on entries still waiting for data.
  assign qual    = (reqOpcode == WRITE_RESP) ? outst_q : {QS{1'b1}};

  prefetcher_addr_match #(
    .LOG_QUEUE_SIZE (LOG_QUEUE_SIZE),
    .ADDR_BITS      (ADDR_BITS)
  ) u_match (
    .entryAddr (addr_q),
    .validMask (valid_q),
    .qualMask  (qual),
    .headPtr   (head_q),
    .key       (key),
    .addrHit   (hit),
    .addrIdx   (hit_idx)
  );

  always_comb begin
    valid_d      = valid_q;
    dvalid_d     = dvalid_q;
    outst_d      = outst_q;
    addr_d       = addr_q;
    data_d       = data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    valid_cnt_d  = valid_cnt_q;
    outst_cnt_d  = outst_cnt_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    err_d        = ERR_NONE;

    case (reqOpcode)
      NOP: ;
      INVALIDATE: begin
        if (hit) begin
          dvalid_d[hit_idx] = 1'b0;
          if (outst_q[hit_idx]) begin
            outst_d[hit_idx] = 1'b0;
            outst_cnt_d      = outst_cnt_q - 1'b1;
          end
        end
      end
      READ: begin
        if (hit && (hit_idx == head_q)) begin
          resp_valid_d = dvalid_q[head_q];
          if (dvalid_q[head_q]) resp_data_d = data_q[head_q];
        end else if (hit && (hit_idx == head_p1)) begin
          // A hit one past head retires the head entry.
          valid_d[head_q]  = 1'b0;
          dvalid_d[head_q] = 1'b0;
          outst_d[head_q]  = 1'b0;
          if (outst_q[head_q]) outst_cnt_d = outst_cnt_q - 1'b1;
          head_d       = head_p1;
          valid_cnt_d  = valid_cnt_q - 1'b1;
          resp_valid_d = dvalid_q[head_p1];
          if (dvalid_q[head_p1]) resp_data_d = data_q[head_p1];
        end
      end
      WRITE_REQ: begin
        if (is_full) begin
          err_d = ERR_FULL;
        end else begin
          valid_d[tail_q]  = 1'b1;
          dvalid_d[tail_q] = 1'b0;
          outst_d[tail_q]  = 1'b1;
          addr_d[tail_q]   = reqAddr;
          tail_d           = tail_q + 1'b1;
          valid_cnt_d      = valid_cnt_q + 1'b1;
          outst_cnt_d      = outst_cnt_q + 1'b1;
        end
      end
      WRITE_RESP: begin
        if (hit) begin
          data_d[hit_idx]   = reqData;
          dvalid_d[hit_idx] = 1'b1;
          outst_d[hit_idx]  = 1'b0;
          outst_cnt_d       = outst_cnt_q - 1'b1;
        end else begin
          err_d = ERR_UNMATCHED;
        end
      end
      default: err_d = ERR_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q      <= '0;
      dvalid_q     <= '0;
      outst_q      <= '0;
      for (int i = 0; i < QS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      valid_cnt_q  <= '0;
      outst_cnt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= ERR_NONE;
    end else begin
      valid_q      <= valid_d;
      dvalid_q     <= dvalid_d;
      outst_q      <= outst_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      valid_cnt_q  <= valid_cnt_d;
      outst_cnt_q  <= outst_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign respValid         = resp_valid_q;
  assign respData          = resp_data_q;
  assign outstandingReqCnt = outst_cnt_q;
  assign errorCode         = err_q;
  assign almostFull        = (valid_cnt_q >= (QS_CNT - {1'b0, crs_almostFullSpacer}));

`ifdef PREFETCHER_DATA_ASSERT_EN
  a_cnt_bound: assert property (@(posedge clk) disable iff (!resetN)
    valid_cnt_q <= QS_CNT);
  a_outst_le_valid: assert property (@(posedge clk) disable iff (!resetN)
    outst_cnt_q <= valid_cnt_q);
  a_resp_after_read: assert property (@(posedge clk) disable iff (!resetN)
    respValid |-> ($past(reqOpcode) == READ));
  a_no_x_out: assert property (@(posedge clk) disable iff (!resetN)
    !$isunknown({respValid, respData, outstandingReqCnt, almostFull, errorCode}));
`endif

endmodule

// File: tb/tb_prefetcher_data.sv
// Directed + randomised bench for prefetcher_data against a queue-based reference model.
module tb_prefetcher_data;
  import prefetcher_pkg::*;

  logic        clk;
  logic        resetN;
  logic [63:0] reqAddr;
  logic [63:0] reqData;
  logic [2:0]  reqOpcode;
  logic [2:0]  crs_almostFullSpacer;
  logic        respValid;
  logic [63:0] respData;
  logic [3:0]  outstandingReqCnt;
  logic        almostFull;
  logic [1:0]  errorCode;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  prefetcher_data dut (
    .clk                  (clk),
    .resetN               (resetN),
    .reqAddr              (reqAddr),
    .reqData              (reqData),
    .reqOpcode            (reqOpcode),
    .crs_almostFullSpacer (crs_almostFullSpacer),
    .respValid            (respValid),
    .respData             (respData),
    .outstandingReqCnt    (outstandingReqCnt),
    .almostFull           (almostFull),
    .errorCode            (errorCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: front of the queue is the head entry.
  typedef struct {
    logic [63:0] addr;
    bit          dv;
    bit          out;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_rv;
  logic [63:0] m_rd;
  logic [1:0]  m_err;
  logic [2:0]  m_head;

  function automatic int find(logic [63:0] a, bit need_out);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].addr == a && (!need_out || mq[i].out)) return i;
    return -1;
  endfunction

  function automatic int out_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].out) n++;
    return n;
  endfunction

  initial begin
    m_rv = 0; m_rd = '0; m_err = '0; m_head = '0;
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        mq.delete();
        m_rv = 0; m_rd = '0; m_err = '0; m_head = '0;
      end else begin
        int i;
        m_rv  = 0;
        m_err = 2'd0;
        case (reqOpcode)
          3'd0: ;
          3'd1: begin
            i = find(reqAddr, 0);
            if (i >= 0) begin mq[i].dv = 0; mq[i].out = 0; end
          end
          3'd2: begin
            i = find(reqAddr, 0);
            if (i == 1) begin
              void'(mq.pop_front());
              m_head = m_head + 3'd1;
              i = 0;
            end
            if (i == 0) begin
              m_rv = mq[0].dv;
              if (m_rv) m_rd = mq[0].data;
            end
          end
          3'd3: begin
            if (mq.size() == 8) m_err = 2'd2;
            else mq.push_back('{addr: reqAddr, dv: 0, out: 1, data: '0});
          end
          3'd4: begin
            i = find(reqAddr, 1);
            if (i >= 0) begin
              mq[i].data = reqData; mq[i].dv = 1; mq[i].out = 0;
            end else m_err = 2'd1;
          end
          default: m_err = 2'd3;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("respValid", 64'(respValid), 64'(m_rv));
      chk("respData", respData, m_rd);
      chk("outstandingReqCnt", 64'(outstandingReqCnt), 64'(out_cnt()));
      chk("almostFull", 64'(almostFull), 64'(mq.size() >= (8 - int'(crs_almostFullSpacer))));
      chk("errorCode", 64'(errorCode), 64'(m_err));
      chk("validCnt", 64'(dut.valid_cnt_q), 64'(mq.size()));
      chk("headPtr", 64'(dut.head_q), 64'(m_head));
    end
  end

  // Called at posedge+2; leaves time at the next posedge+2 with the op applied.
  task automatic op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] d);
    reqOpcode = o; reqAddr = a; reqData = d;
    @(posedge clk); #2;
    reqOpcode = 3'd0;
  endtask

  logic exp_af [5];

  initial begin
    exp_af = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    resetN = 1'b0; reqAddr = '0; reqData = '0; reqOpcode = 3'd0; crs_almostFullSpacer = 3'd0;
    #1 cmp_en = 1;
    repeat (3) @(posedge clk);
    #2 resetN = 1'b1;

    chk("reset outstanding", 64'(outstandingReqCnt), 64'd0);
    chk("reset respValid", 64'(respValid), 64'd0);
    chk("reset errorCode", 64'(errorCode), 64'd0);
    chk("reset almostFull", 64'(almostFull), 64'd0);

    for (int i = 0; i < 5; i++) op(WRITE_REQ, 64'hdeadbef0 + 64'(i), '0);
    chk("fill outstanding=5", 64'(outstandingReqCnt), 64'd5);
    chk("fill validCnt=5", 64'(dut.valid_cnt_q), 64'd5);
    chk("fill dataValid=0", 64'(dut.dvalid_q), 64'd0);

    for (int i = 0; i < 5; i++) op(WRITE_RESP, 64'hdeadbef0 + 64'(i), 64'(16 * (i + 1)));
    chk("resp outstanding=0", 64'(outstandingReqCnt), 64'd0);
    chk("resp errorCode=0", 64'(errorCode), 64'd0);
    op(WRITE_RESP, 64'hdeadbef5, 64'h60);
    chk("unmatched resp err", 64'(errorCode), 64'd1);

    op(READ, 64'hdeadbef0, '0);
    chk("read head valid", 64'(respValid), 64'd1);
    chk("read head data", respData, 64'h10);
    op(READ, 64'hdeadbef0, '0);
    chk("read head again valid", 64'(respValid), 64'd1);
    chk("read head again data", respData, 64'h10);
    op(READ, 64'hdeadbef1, '0);
    chk("read head+1 data", respData, 64'h20);
    chk("read head+1 headPtr", 64'(dut.head_q), 64'd1);
    op(READ, 64'hdeadbef0, '0);
    chk("read popped miss", 64'(respValid), 64'd0);
    op(READ, 64'hdeadbef3, '0);
    chk("read deep miss", 64'(respValid), 64'd0);
    op(READ, 64'h123, '0);
    chk("read miss", 64'(respValid), 64'd0);
    chk("read miss data hold", respData, 64'h20);

    op(INVALIDATE, 64'hdeadbef2, '0);
    chk("invalidate dv[2]", 64'(dut.dvalid_q[2]), 64'd0);
    op(INVALIDATE, 64'h1234, '0);
    op(READ, 64'hdeadbef2, '0);
    chk("read invalidated", 64'(respValid), 64'd0);
    chk("read invalidated head", 64'(dut.head_q), 64'd2);

    crs_almostFullSpacer = 3'd2;
    for (int i = 0; i < 5; i++) begin
      op(WRITE_REQ, 64'h100 + 64'(i), '0);
      chk($sformatf("almostFull step %0d", i), 64'(almostFull), 64'(exp_af[i]));
    end
    chk("full validCnt", 64'(dut.valid_cnt_q), 64'd8);
    op(WRITE_REQ, 64'h105, '0);
    chk("full err", 64'(errorCode), 64'd2);
    op(NOP, '0, '0);
    chk("nop clears err", 64'(errorCode), 64'd0);
    crs_almostFullSpacer = 3'd0;
    #1 chk("spacer0 full", 64'(almostFull), 64'd1);

    op(3'd5, 64'h100, '0);
    chk("illegal err", 64'(errorCode), 64'd3);
    op(3'd7, 64'h100, '0);
    op(INVALIDATE, 64'h100, '0);
    chk("inval outstanding", 64'(outstandingReqCnt), 64'd4);
    op(WRITE_RESP, 64'h101, 64'hcafe);

    // Asynchronous reset in the middle of a cycle.
    resetN = 1'b0;
    #1;
    chk("async rst respData", respData, 64'd0);
    chk("async rst outstanding", 64'(outstandingReqCnt), 64'd0);
    @(posedge clk); #2 resetN = 1'b1;
    op(READ, 64'hdeadbef3, '0);
    chk("read after reset", 64'(respValid), 64'd0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0] o;
      o = (n % 13 == 12) ? 3'd6 : 3'($urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) crs_almostFullSpacer = 3'($urandom_range(0, 7));
      op(o, 64'h200 + 64'($urandom_range(0, 5)), 64'($urandom));
    end

    op(NOP, '0, '0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetcher_data.md
PREFETCHER_DATA -- requirements
Module: prefetcher_data

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LOG_QUEUE_SIZE, 3, log2 of entry count; QUEUE_SIZE = 2^LOG_QUEUE_SIZE.
- LOG_BLOCK_DATA_BYTES, 3, log2 of block bytes; BLOCK_DATA_SIZE_BITS = 8 * 2^LOG_BLOCK_DATA_BYTES.
- ADDR_BITS, 64, address width.
REQ-002 Ports (name, direction, width, meaning); all vectors are ascending [0:W-1]; one clock; reset is asynchronous and active-low:
- clk, in, 1, clock, rising edge.
- resetN, in, 1, asynchronous active-low reset.
- reqAddr, in, ADDR_BITS, request block address.
- reqData, in, BLOCK_DATA_SIZE_BITS, WRITE_RESP fill data.
- reqOpcode, in, 3, request opcode.
- crs_almostFullSpacer, in, LOG_QUEUE_SIZE, almost-full margin in entries.
- respValid, out, 1, registered read hit with valid data.
- respData, out, BLOCK_DATA_SIZE_BITS, registered read data.
- outstandingReqCnt, out, LOG_QUEUE_SIZE+1, number of entries awaiting fill.
- almostFull, out, 1, validCnt >= QUEUE_SIZE - crs_almostFullSpacer.
- errorCode, out, 2, error raised by the previous cycle's request.

Function
REQ-003 Circular FIFO of QUEUE_SIZE entries, each holding valid, dataValid, outstanding, address and data; headPtr/tailPtr are LOG_QUEUE_SIZE bits wide and wrap; validCnt spans 0..QUEUE_SIZE; isEmpty = (validCnt==0); isFull = (validCnt==QUEUE_SIZE).
REQ-004 Opcodes: 0 NOP, 1 INVALIDATE, 2 READ, 3 WRITE_REQ, 4 WRITE_RESP; 5-7 illegal. One request is processed per cycle and all state updates on the rising edge.
REQ-005 Address match compares reqAddr against valid entries only; if several entries match, the one closest to head wins.
REQ-006 WRITE_REQ, not full: allocate at tail with valid=1, outstanding=1, dataValid=0 and address=reqAddr; tail++; outstandingReqCnt++. Duplicate addresses are allocated normally.
REQ-007 WRITE_REQ while full: no state change; errorCode=2.
REQ-008 WRITE_RESP matching an outstanding entry: data=reqData, dataValid=1, outstanding=0, outstandingReqCnt--.
REQ-009 WRITE_RESP with no outstanding match: ignored; errorCode=1.
REQ-010 READ hitting the head: respValid=dataValid[head], respData=data[head]; no pop.
REQ-011 READ hitting head+1: pop the head (validCnt--, and outstandingReqCnt-- if the popped entry was outstanding); respValid=dataValid[head+1]; respData=its data.
REQ-012 READ in every other case (miss, empty queue, hit deeper than head+1): respValid=0; no state change; no error. respData holds its previous value whenever respValid=0.
REQ-013 respValid is 0 for every non-READ cycle.
REQ-014 INVALIDATE hit: dataValid=0; if the entry was outstanding, outstanding=0 and outstandingReqCnt--. Entry stays valid. INVALIDATE miss: no-op.
REQ-015 Illegal opcode: no state change; errorCode=3.
REQ-016 errorCode is registered and reflects only the latest request; it returns to 0 on the next error-free request, NOP included.
REQ-017 almostFull is combinational from validCnt and crs_almostFullSpacer; with spacer=0 it equals isFull.

Reset
REQ-018 With resetN=0, asynchronously clear: headPtr, tailPtr, validCnt, all valid/dataValid/outstanding bits, respValid, respData, outstandingReqCnt and errorCode to 0. Entry address and data are cleared to 0.
REQ-019 Reset asserted mid-operation discards all entries with no response generated.

Configuration
REQ-020 Macro PREFETCHER_DATA_ASSERT_EN, when defined, compiles in concurrent assertions: validCnt <= QUEUE_SIZE; outstandingReqCnt <= validCnt; respValid implies the previous opcode was READ; no X on outputs after reset. When undefined, no assertion code is present and function is identical.

Structure
REQ-021 Package prefetcher_pkg holds the opcode enum (NOP, INVALIDATE, READ, WRITE_REQ, WRITE_RESP) and the error-code constants (0 none, 1 unmatched response, 2 full, 3 illegal opcode).
REQ-022 Sub-module prefetcher_addr_match implements the priority CAM lookup: inputs are the address matrix, valid mask, qualifier mask, headPtr and key; outputs are addrHit and addrIdx.

Verification
REQ-023 Reset, then WRITE_REQ 0xdeadbef0..0xdeadbef4 -> validCnt=5, outstandingReqCnt=5, all entries dataValid=0.
REQ-024 WRITE_RESP for the same addresses with data 0x10..0x50, then 0xdeadbef5 -> all entries dataValid, outstandingReqCnt=0; the final unmatched response gives errorCode=1.
REQ-025 READ 0xdeadbef0 twice -> respValid=1 and respData=0x10 both times. READ 0xdeadbef1 -> 0x20 and headPtr=1. Then READ 0xdeadbef0, READ 0xdeadbef3 and READ 0x123 -> respValid=0 for each.
REQ-026 INVALIDATE 0xdeadbef2 -> dataValid[2]=0. INVALIDATE 0x1234 -> no change. READ 0xdeadbef2 -> respValid=0 and headPtr=2.
REQ-027 With spacer=2 and 3 valid entries, WRITE_REQ x5 -> almostFull=0,0,1,1,1 and isFull only after the 5th. A further WRITE_REQ gives errorCode=2 with no change; a following NOP gives errorCode=0.
